// File: rtl/camasir_pkg.sv
// Shared types and defaults for the laundry-load feeder.
package camasir_pkg;
  localparam int ITEM_W_DEF = 4;
  localparam int LOAD_W_DEF = 16;

  typedef enum logic [1:0] {
    BOS    = 2'd0,
    BASLAT = 2'd1,
    BEKLE  = 2'd2
  } durum_e;
endpackage

// File: rtl/camasir_toplayici_if.sv
// Item handshake plus pipeline dispatch signals of the laundry-load feeder.
interface camasir_toplayici_if #(
  parameter int ITEM_W = 4,
  parameter int LOAD_W = 16,
  parameter int DEPTH  = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              parca_gecerli;
  logic [ITEM_W-1:0] parca;
  logic              parca_hazir;
  logic [LOAD_W-1:0] camasir;
  logic              basla;
  logic              bitti;
  logic              mesgul;
  logic [CW-1:0]     kuyruk;

  modport master (
    output parca_gecerli, parca, bitti,
    input  parca_hazir, camasir, basla, mesgul, kuyruk
  );

  modport slave (
    input  parca_gecerli, parca, bitti,
    output parca_hazir, camasir, basla, mesgul, kuyruk
  );
endinterface

// File: rtl/yuk_fifo.sv
// Load queue: DEPTH entries of W bits, circular pointers with an occupancy count.
module yuk_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i)  rd_q <= inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/camasir_toplayici.sv
// Packs item codes into loads, queues them and dispatches one load at a time
// to the wash pipeline with a start pulse / done-edge handshake.
module camasir_toplayici
  import camasir_pkg::*;
#(
  parameter int ITEM_W  = ITEM_W_DEF,
  parameter int LOAD_W  = LOAD_W_DEF,
  parameter int TIMEOUT = 8,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  camasir_toplayici_if.slave bus
);
  localparam int N  = LOAD_W / ITEM_W;
  localparam int KW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [KW-1:0]     k_q, k_d;
  logic [LOAD_W-1:0] pack_q, pack_d, pack_nx;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [LOAD_W-1:0] cam_q, cam_d;
  durum_e            st_q, st_d;
  logic              bitti_q;

  logic              full, empty, push, pop, nz, flush;
  logic [LOAD_W-1:0] head;
  logic [CW-1:0]     cnt;

  assign nz    = bus.parca_gecerli & ~full & (bus.parca != '0);
  // A nonzero item arriving makes the cycle non-idle, so it wins over a pending flush.
  assign flush = (k_q != '0) & (tmo_q == TW'(TIMEOUT)) & ~nz & ~full;
  assign push  = (nz & (k_q == KW'(N - 1))) | flush;
  assign pop   = (st_q == BOS) & ~empty;

  always_comb begin
    pack_nx = pack_q;
    if (nz) pack_nx = pack_q | (LOAD_W'(bus.parca) << (ITEM_W * int'(k_q)));
    pack_d = pack_nx;
    k_d    = k_q;
    tmo_d  = tmo_q;
    if (push) begin
      pack_d = '0;
      k_d    = '0;
      tmo_d  = '0;
    end else if (nz) begin
      k_d   = k_q + 1'b1;
      tmo_d = '0;
    end else if ((k_q != '0) && (tmo_q != TW'(TIMEOUT))) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_comb begin
    st_d  = st_q;
    cam_d = cam_q;
    case (st_q)
      BOS: begin
        if (pop) begin
          st_d  = BASLAT;
          cam_d = head;
        end
      end
      BASLAT:  st_d = BEKLE;
      BEKLE:   if (bus.bitti & ~bitti_q) st_d = BOS;
      default: st_d = BOS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      pack_q  <= '0;
      tmo_q   <= '0;
      cam_q   <= '0;
      st_q    <= BOS;
      bitti_q <= 1'b0;
    end else begin
      k_q     <= k_d;
      pack_q  <= pack_d;
      tmo_q   <= tmo_d;
      cam_q   <= cam_d;
      st_q    <= st_d;
      bitti_q <= bus.bitti;
    end
  end

  yuk_fifo #(.W(LOAD_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (pack_nx),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );

  assign bus.parca_hazir = ~full;
  assign bus.camasir     = cam_q;
  assign bus.basla       = (st_q == BASLAT);
  assign bus.mesgul      = (st_q != BOS);
  assign bus.kuyruk      = cnt;
endmodule

// File: tb/tb_camasir_toplayici.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_camasir_toplayici;
  localparam int IW = 4, LW = 16, N = 4, TMO = 8, DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  camasir_toplayici_if #(.ITEM_W(IW), .LOAD_W(LW), .DEPTH(DEPTH)) bus ();

  camasir_toplayici #(.ITEM_W(IW), .LOAD_W(LW), .TIMEOUT(TMO), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model: loads waiting, partial load, item count, idle cycles, in-flight load.
  logic [LW-1:0] mq[$];
  logic [LW-1:0] m_part = '0, m_cam = '0;
  int m_k = 0, m_idle = 0;
  bit m_busy = 0, m_start = 0;
  logic m_bprev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit nz, rise;
    int pre;
    if (!rst_n) begin
      mq.delete();
      m_part = '0; m_cam = '0; m_k = 0; m_idle = 0;
      m_busy = 0; m_start = 0; m_bprev = 1'b0;
      return;
    end
    pre  = mq.size();
    nz   = bus.parca_gecerli && (pre < DEPTH) && (bus.parca != 0);
    rise = bus.bitti && !m_bprev;
    m_bprev = bus.bitti;
    if (!m_busy) begin
      if (pre > 0) begin
        m_cam = mq.pop_front();
        m_busy = 1; m_start = 1;
      end
    end else if (m_start) m_start = 0;
    else if (rise) m_busy = 0;
    if (nz) begin
      m_part = m_part | (LW'(bus.parca) << (m_k * IW));
      m_k++; m_idle = 0;
      if (m_k == N) begin mq.push_back(m_part); m_part = '0; m_k = 0; end
    end else if (m_k > 0) begin
      if (m_idle >= TMO && pre < DEPTH) begin
        mq.push_back(m_part); m_part = '0; m_k = 0; m_idle = 0;
      end else if (m_idle < TMO) m_idle++;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("hazir",   32'(bus.parca_hazir), 32'(mq.size() < DEPTH));
    chk("kuyruk",  32'(bus.kuyruk),      32'(mq.size()));
    chk("basla",   32'(bus.basla),       32'(m_start));
    chk("mesgul",  32'(bus.mesgul),      32'(m_busy));
    chk("camasir", 32'(bus.camasir),     32'(m_cam));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] c);
    int n = 0;
    bus.parca_gecerli = 1'b1;
    bus.parca = c;
    @(negedge clk);
    while (!bus.parca_hazir && n < 200) begin @(negedge clk); n++; end
    chk("send_accept", 32'(bus.parca_hazir), 32'd1);
    @(posedge clk); #1;
    bus.parca_gecerli = 1'b0;
    bus.parca = '0;
  endtask

  task automatic wait_basla(output int cnt);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!bus.basla && cnt < 100);
    chk("basla_seen", 32'(bus.basla), 32'd1);
  endtask

  task automatic pulse_bitti();
    tick(); bus.bitti = 1'b1;
    tick(); bus.bitti = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    bus.parca_gecerli = 1'b0;
    while ((mq.size() != 0 || m_k != 0 || m_busy) && c < 600) begin
      tick();
      bus.bitti = (c % 3 == 0);
      c++;
    end
    bus.bitti = 1'b0;
    tick(); tick();
    chk("drain_idle", 32'(bus.mesgul), 32'd0);
  endtask

  initial begin
    int n, nb, w;
    logic [LW-1:0] cb;
    bus.parca_gecerli = 1'b0;
    bus.parca = '0;
    bus.bitti = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hazir",   32'(bus.parca_hazir), 32'd1);
    chk("rst_mesgul",  32'(bus.mesgul),      32'd0);
    chk("rst_basla",   32'(bus.basla),       32'd0);
    chk("rst_kuyruk",  32'(bus.kuyruk),      32'd0);
    chk("rst_camasir", 32'(bus.camasir),     32'd0);
    rst_n = 1'b1;
    tick();

    // 1: full load, latency and completion
    for (int i = 1; i <= 4; i++) send(4'(i));
    wait_basla(n);
    chk("t1_latency", 32'(n), 32'd2);
    chk("t1_camasir", 32'(bus.camasir), 32'h4321);
    chk("t1_mesgul",  32'(bus.mesgul),  32'd1);
    @(negedge clk);
    chk("t1_basla_once", 32'(bus.basla), 32'd0);
    pulse_bitti();
    @(negedge clk);
    chk("t1_done", 32'(bus.mesgul), 32'd0);

    // 2: partial flush; a code-0 item does not restart the idle count
    tick();
    send(4'd5); send(4'd6);
    tick(); tick(); tick();
    send(4'd0);
    wait_basla(n);
    chk("t2_latency", 32'(n), 32'd7);
    chk("t2_camasir", 32'(bus.camasir), 32'h0065);
    pulse_bitti();
    drain();

    // 3: queue fills, item 13 stalls until a completion frees a slot
    for (int i = 1; i <= 12; i++) send(4'(i));
    @(negedge clk);
    chk("t3_kuyruk",  32'(bus.kuyruk),      32'd2);
    chk("t3_hazir",   32'(bus.parca_hazir), 32'd0);
    chk("t3_mesgul",  32'(bus.mesgul),      32'd1);
    chk("t3_camasir", 32'(bus.camasir),     32'h4321);
    tick();
    bus.parca_gecerli = 1'b1; bus.parca = 4'hD;
    repeat (5) begin @(negedge clk); chk("t3_stall", 32'(bus.parca_hazir), 32'd0); end
    pulse_bitti();
    w = 0;
    while (!bus.parca_hazir && w < 20) begin @(negedge clk); w++; end
    chk("t3_resume",   32'(bus.parca_hazir), 32'd1);
    chk("t3_next_cam", 32'(bus.camasir),     32'h8765);
    chk("t3_next_bsl", 32'(bus.basla),       32'd1);
    tick();
    bus.parca_gecerli = 1'b0; bus.parca = '0;
    drain();

    // 4: bitti held high must not complete the next load
    for (int i = 1; i <= 4; i++) send(4'(i));
    for (int i = 9; i <= 12; i++) send(4'(i));
    bus.bitti = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    chk("t4_stuck",   32'(bus.mesgul),  32'd1);
    chk("t4_camasir", 32'(bus.camasir), 32'hCBA9);
    chk("t4_kuyruk",  32'(bus.kuyruk),  32'd0);
    tick(); bus.bitti = 1'b0;
    tick(); tick(); bus.bitti = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("t4_done", 32'(bus.mesgul), 32'd0);
    bus.bitti = 1'b0;
    drain();

    // 5: reset in BEKLE with a queued load and a partial load
    for (int i = 1; i <= 8; i++) send(4'(i));
    send(4'd1); send(4'd2);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_camasir", 32'(bus.camasir),     32'd0);
    chk("t5_basla",   32'(bus.basla),       32'd0);
    chk("t5_mesgul",  32'(bus.mesgul),      32'd0);
    chk("t5_kuyruk",  32'(bus.kuyruk),      32'd0);
    chk("t5_hazir",   32'(bus.parca_hazir), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulse_bitti();
    @(negedge clk);
    chk("t5_ignore_bitti", 32'(bus.mesgul), 32'd0);
    tick();
    send(4'd3); send(4'd5); send(4'd7); send(4'd9);
    nb = 0; cb = '0;
    repeat (30) begin
      @(negedge clk);
      if (bus.basla) begin nb++; cb = bus.camasir; end
    end
    chk("t5_loads",   32'(nb), 32'd1);
    chk("t5_camasir", 32'(cb), 32'h9753);
    drain();

    // 6: pop and push on the same edge keep the count, FIFO order preserved
    for (int i = 1; i <= 11; i++) send(4'(i));
    bus.bitti = 1'b1;
    tick();
    bus.bitti = 1'b0;
    send(4'hC);
    @(negedge clk);
    chk("t6_kuyruk",  32'(bus.kuyruk),  32'd1);
    chk("t6_basla",   32'(bus.basla),   32'd1);
    chk("t6_camasir", 32'(bus.camasir), 32'h8765);
    pulse_bitti();
    wait_basla(n);
    chk("t6_order", 32'(bus.camasir), 32'hCBA9);
    drain();

    // random traffic with varying load, bitti activity and one reset
    begin
      int vprob = 50;
      for (int c = 0; c < 2500; c++) begin
        tick();
        if (c % 200 == 0) vprob = (c / 200) % 3 == 0 ? 90 : ((c / 200) % 3 == 1 ? 10 : 50);
        if (c == 1300) begin #2 rst_n = 1'b0; end
        if (c == 1302) rst_n = 1'b1;
        bus.parca_gecerli = ($urandom_range(0, 99) < vprob);
        bus.parca = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        if ($urandom_range(0, 99) < 30) bus.bitti = ~bus.bitti;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
